// File: rtl/fetch_align_if.sv
// ----------------------------------------------------------------------------
// fetch_align_if
// Purpose : groups the fetch-word stream, the instruction stream and the
//           redirect signals of the fetch aligner into one bundle.
// Signals : flush_i/redirect_pc_i  redirect request and target PC
//           fetch_valid_i/fetch_rdata_i/fetch_ready_o  I$ word handshake
//           instr_valid_o/instr_raw_o/instr_pc_o/instr_ready_i  instruction
//           handshake towards the RVC expander
// Modports: slave  - the aligner itself
//           master - the surrounding fetch unit (or a testbench)
// ----------------------------------------------------------------------------
interface fetch_align_if;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_raw_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    modport slave (
        input  flush_i, redirect_pc_i, fetch_valid_i, fetch_rdata_i, instr_ready_i,
        output fetch_ready_o, instr_valid_o, instr_raw_o, instr_pc_o
    );

    modport master (
        output flush_i, redirect_pc_i, fetch_valid_i, fetch_rdata_i, instr_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_raw_o, instr_pc_o
    );
endinterface

// File: rtl/fetch_align.sv
// ----------------------------------------------------------------------------
// fetch_align
// Purpose : splits word-aligned 32-bit fetch words into one instruction per
//           handshake. 16-bit (compressed) instructions are zero-extended,
//           32-bit instructions straddling two words are re-assembled. Tracks
//           the PC of every emitted instruction and accepts halfword-aligned
//           redirects.
// Ports   : clk    - clock
//           rst_n  - asynchronous reset, active low
//           bus    - fetch_align_if.slave (fetch words in, instructions out,
//                    flush/redirect in)
// Params  : RESET_PC - PC of the first instruction after reset (bit0 ignored)
// Config  : FETCH_ALIGN_RVC_EN - when defined, compressed instructions are
//           supported (halfword buffer, HALF and SKIP states). When undefined
//           every fetch word is emitted as one 32-bit instruction and the PC
//           stays word aligned.
// Outputs are combinational from the registered state and the fetch inputs,
// so an instruction can be emitted in the same cycle its word arrives.
// ----------------------------------------------------------------------------
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_align_if.slave  bus
);

    logic        w_valid;
    logic        w_fready;
    logic [31:0] w_raw;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pc;
    logic        w_hs;
    logic        w_unused;

    assign w_hs = w_valid & bus.instr_ready_i;

`ifdef FETCH_ALIGN_RVC_EN
    typedef enum logic [1:0] {
        ST_ALIGNED = 2'd0,
        ST_HALF    = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

    state_t      r_st;
    state_t      w_st_nxt;
    logic [15:0] r_hw;
    logic [15:0] w_hw_nxt;
    logic        w_lo_is_c;
    logic        w_hw_is_c;

    assign w_lo_is_c = (bus.fetch_rdata_i[1:0] != 2'b11);
    assign w_hw_is_c = (r_hw[1:0] != 2'b11);
    assign w_unused  = bus.redirect_pc_i[0];

    // State, buffered upper halfword and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= RESET_PC[1] ? ST_SKIP : ST_ALIGNED;
            r_hw <= 16'h0000;
            r_pc <= {RESET_PC[31:1], 1'b0};
        end else begin
            r_st <= w_st_nxt;
            r_hw <= w_hw_nxt;
            r_pc <= w_pc_nxt;
        end
    end

    // Next-state and instruction/handshake decode; flush overrides everything.
    always_comb begin
        w_valid  = 1'b0;
        w_fready = 1'b0;
        w_raw    = 32'h0000_0000;
        w_st_nxt = r_st;
        w_hw_nxt = r_hw;
        w_pc_nxt = r_pc;
        if (bus.flush_i) begin
            // The stale word in flight is accepted and dropped.
            w_fready = 1'b1;
            w_pc_nxt = {bus.redirect_pc_i[31:1], 1'b0};
            w_st_nxt = bus.redirect_pc_i[1] ? ST_SKIP : ST_ALIGNED;
        end else begin
            case (r_st)
                ST_ALIGNED: begin
                    w_valid  = bus.fetch_valid_i;
                    w_fready = bus.instr_ready_i;
                    if (w_lo_is_c) begin
                        w_raw = {16'h0000, bus.fetch_rdata_i[15:0]};
                        if (w_hs) begin
                            w_hw_nxt = bus.fetch_rdata_i[31:16];
                            w_st_nxt = ST_HALF;
                            w_pc_nxt = r_pc + 32'd2;
                        end else begin
                            w_pc_nxt = r_pc;
                        end
                    end else begin
                        w_raw = bus.fetch_rdata_i;
                        if (w_hs) begin
                            w_pc_nxt = r_pc + 32'd4;
                        end else begin
                            w_pc_nxt = r_pc;
                        end
                    end
                end
                ST_HALF: begin
                    if (w_hw_is_c) begin
                        // Buffered halfword is a full instruction; the word
                        // on the bus is not needed yet.
                        w_valid  = 1'b1;
                        w_raw    = {16'h0000, r_hw};
                        w_fready = 1'b0;
                        if (w_hs) begin
                            w_st_nxt = ST_ALIGNED;
                            w_pc_nxt = r_pc + 32'd2;
                        end else begin
                            w_pc_nxt = r_pc;
                        end
                    end else begin
                        // Straddling 32-bit instruction: low half buffered,
                        // high half is the low half of the incoming word.
                        w_valid  = bus.fetch_valid_i;
                        w_raw    = {bus.fetch_rdata_i[15:0], r_hw};
                        w_fready = bus.instr_ready_i;
                        if (w_hs) begin
                            w_hw_nxt = bus.fetch_rdata_i[31:16];
                            w_pc_nxt = r_pc + 32'd4;
                        end else begin
                            w_pc_nxt = r_pc;
                        end
                    end
                end
                ST_SKIP: begin
                    // PC points at the upper half: drop the low half.
                    w_fready = 1'b1;
                    if (bus.fetch_valid_i) begin
                        w_hw_nxt = bus.fetch_rdata_i[31:16];
                        w_st_nxt = ST_HALF;
                    end else begin
                        w_st_nxt = ST_SKIP;
                    end
                end
                default: begin
                    w_st_nxt = ST_ALIGNED;
                end
            endcase
        end
    end
`else
    assign w_unused = ^bus.redirect_pc_i[1:0];

    // Word-aligned PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    // Every fetch word is one instruction; flush overrides.
    always_comb begin
        w_valid  = 1'b0;
        w_fready = 1'b0;
        w_raw    = 32'h0000_0000;
        w_pc_nxt = r_pc;
        if (bus.flush_i) begin
            w_fready = 1'b1;
            w_pc_nxt = {bus.redirect_pc_i[31:2], 2'b00};
        end else begin
            w_valid  = bus.fetch_valid_i;
            w_fready = bus.instr_ready_i;
            w_raw    = bus.fetch_rdata_i;
            if (w_hs) begin
                w_pc_nxt = r_pc + 32'd4;
            end else begin
                w_pc_nxt = r_pc;
            end
        end
    end
`endif

    // Outputs are held quiet while reset is asserted.
    assign bus.instr_valid_o = rst_n & w_valid;
    assign bus.fetch_ready_o = rst_n & w_fready;
    assign bus.instr_raw_o   = rst_n ? w_raw : 32'h0000_0000;
    assign bus.instr_pc_o    = r_pc;

endmodule

// File: tb/tb_fetch_align.sv
// ----------------------------------------------------------------------------
// tb_fetch_align
// Self-checking bench for fetch_align. Program memory is a halfword array;
// the reference walks it instruction by instruction from the current PC
// (compressed = low bits != 11, length 2, otherwise length 4), while a fetch
// driver supplies sequential aligned words starting at the word holding the
// PC. Works for both settings of FETCH_ALIGN_RVC_EN.
// ----------------------------------------------------------------------------
module tb_fetch_align;

`ifdef FETCH_ALIGN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_align_if bus ();

    fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:255];

    // model / driver state
    logic [31:0] m_pc;
    logic [31:0] f_addr;
    logic        f_valid;
    logic [31:0] f_data;
    logic        prev_stall;
    logic [31:0] prev_raw;
    logic [31:0] prev_pc;
    int          idle;
    bit          hung;
    // last sampled outputs, for directed checks
    logic        s_valid;
    logic        s_fready;
    logic [31:0] s_raw;
    logic [31:0] s_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        return mem[a[8:1]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] a2;
        a2 = a + 32'd2;
        return {hw_at(a2), hw_at(a)};
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        mem[a[8:1]]         = w[15:0];
        mem[a[8:1] + 8'd1]  = w[31:16];
    endtask

    // one clock cycle: drive at negedge, sample 1 time unit later, update model
    task automatic step(input bit flush, input logic [31:0] tgt, input int p_valid, input int p_ready);
        logic [15:0] lo;
        logic [31:0] exp_raw;
        logic [31:0] next_pc;
        @(negedge clk);
        if (!f_valid && ($urandom_range(99) < p_valid)) begin
            f_valid = 1'b1;
            f_data  = word_at(f_addr);
        end
        bus.fetch_valid_i = f_valid;
        bus.fetch_rdata_i = f_data;
        bus.instr_ready_i = ($urandom_range(99) < p_ready);
        bus.flush_i       = flush;
        bus.redirect_pc_i = tgt;
        #1;
        s_valid  = bus.instr_valid_o;
        s_fready = bus.fetch_ready_o;
        s_raw    = bus.instr_raw_o;
        s_pc     = bus.instr_pc_o;
        if (flush) begin
            check_eq("flush_valid", {31'd0, s_valid}, 32'd0);
            check_eq("flush_fready", {31'd0, s_fready}, 32'd1);
            m_pc       = RVC ? (tgt & ~32'd1) : (tgt & ~32'd3);
            f_addr     = m_pc & ~32'd3;
            f_valid    = 1'b0;
            prev_stall = 1'b0;
            idle       = 0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", {31'd0, s_valid}, 32'd1);
                check_eq("stall_raw", s_raw, prev_raw);
                check_eq("stall_pc", s_pc, prev_pc);
            end
            if (s_valid && !bus.instr_ready_i) begin
                check_eq("stall_fready", {31'd0, s_fready}, 32'd0);
            end
            if (s_valid && bus.instr_ready_i) begin
                lo = hw_at(m_pc);
                if (RVC && (lo[1:0] != 2'b11)) begin
                    exp_raw = {16'h0000, lo};
                    next_pc = m_pc + 32'd2;
                end else begin
                    exp_raw = {hw_at(m_pc + 32'd2), lo};
                    next_pc = m_pc + 32'd4;
                end
                check_eq("instr_raw", s_raw, exp_raw);
                check_eq("instr_pc", s_pc, m_pc);
                m_pc = next_pc;
                idle = 0;
            end else begin
                idle++;
            end
            if (f_valid && s_fready) begin
                f_addr  = f_addr + 32'd4;
                f_valid = 1'b0;
            end
            prev_stall = s_valid && !bus.instr_ready_i;
            prev_raw   = s_raw;
            prev_pc    = s_pc;
        end
        if (idle > 200 && !hung) begin
            hung = 1'b1;
            check_eq("progress_timeout", idle, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        put_word(32'h0000_0000, 32'h0000_0013);
        put_word(32'h0000_0004, 32'h4585_4501);
        put_word(32'h0000_0008, 32'h0013_4501);
        put_word(32'h0000_000C, 32'h4585_0000);
        put_word(32'h0000_0100, 32'h4585_4501);

        m_pc = 32'h0; f_addr = 32'h0; f_valid = 1'b0; f_data = 32'h0;
        prev_stall = 1'b0; prev_raw = 32'h0; prev_pc = 32'h0; idle = 0; hung = 1'b0;

        // reset: outputs forced quiet even with both sides ready
        rst_n = 1'b0;
        bus.flush_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.fetch_valid_i = 1'b1; bus.fetch_rdata_i = 32'h0000_0013; bus.instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        check_eq("rst_fready", {31'd0, bus.fetch_ready_o}, 32'd0);
        check_eq("rst_raw", bus.instr_raw_o, 32'd0);
        check_eq("rst_pc", bus.instr_pc_o, 32'd0);
        bus.fetch_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // directed: first word, then a pair of compressed instructions
        step(1'b0, 32'h0, 100, 100);
        check_eq("t1_fready", {31'd0, s_fready}, 32'd1);
        check_eq("t1_raw", s_raw, 32'h0000_0013);
        check_eq("t1_pc", s_pc, 32'h0000_0000);
        step(1'b0, 32'h0, 100, 100);
`ifdef FETCH_ALIGN_RVC_EN
        check_eq("t2_raw_lo", s_raw, 32'h0000_4501);
        check_eq("t2_pc_lo", s_pc, 32'h0000_0004);
        step(1'b0, 32'h0, 100, 100);
        check_eq("t2_raw_hi", s_raw, 32'h0000_4585);
        check_eq("t2_pc_hi", s_pc, 32'h0000_0006);
        check_eq("t2_fready", {31'd0, s_fready}, 32'd0);
`else
        check_eq("off_raw", s_raw, 32'h4585_4501);
        check_eq("off_pc", s_pc, 32'h0000_0004);
`endif
        repeat (6) step(1'b0, 32'h0, 100, 100);

        // directed: redirect to an upper halfword
        step(1'b1, 32'h0000_0102, 100, 100);
        step(1'b0, 32'h0, 100, 100);
`ifdef FETCH_ALIGN_RVC_EN
        check_eq("t4_bubble", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'h0, 100, 100);
        check_eq("t4_raw", s_raw, 32'h0000_4585);
        check_eq("t4_pc", s_pc, 32'h0000_0102);
`else
        check_eq("off_redir_raw", s_raw, 32'h4585_4501);
        check_eq("off_redir_pc", s_pc, 32'h0000_0100);
`endif

        // randomized program, stalls on both sides, random redirects
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(1) == 0) mem[i][1:0] = 2'b11;
        end
        step(1'b1, 32'hFFFF_FFF2, 100, 100);
        for (int c = 0; c < 4000 && !hung; c++) begin
            if ($urandom_range(99) < 3) begin
                tgt = $urandom;
                if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h1F);
                step(1'b1, tgt, 70, 70);
            end else begin
                step(1'b0, 32'h0, 70, 70);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
